// File: rtl/fft_output_framer_pkg.sv
// Shared FFT types and constants for the output framer and its skid buffer.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package fft_output_framer_pkg;

  localparam int DATA_W = 32;
  localparam int PT_W   = 4;
  localparam int FCNT_W = 16;
  localparam int CNT_W  = 16;

  // Valid-qualified complex sample delivered to the downstream consumer.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_i;
  } fft_data_bus_t;

  // Control fields handed from the FFT controller to the compute side.
  typedef struct packed {
    logic [PT_W-1:0] point;
  } fft_cont_to_comp_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } frame_state_e;

  // Index of the final sample in a frame of 2^pt samples.
  function automatic logic [CNT_W-1:0] last_index(input logic [PT_W-1:0] pt);
    return CNT_W'((32'd1 << pt) - 32'd1);
  endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry skid buffer with a registered head; payload width parameterised.
// Latency: 1 cycle from accepted input to output valid.
// Backpressure: in_rdy_o drops only when both entries are full and the head is not leaving.
module fft_skid_buf #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         enq, deq;

  // A full buffer still accepts a word when the head drains in the same cycle.
  assign deq       = (cnt_q != 2'd0) && out_rdy_i;
  assign in_rdy_o  = (cnt_q != 2'd2) || out_rdy_i;
  assign enq       = in_vld_i && in_rdy_o;
  assign out_vld_o = (cnt_q != 2'd0);
  assign out_dat_o = head_q;

  // Next-state for occupancy and entries; the head only moves when it is consumed.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({enq, deq})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_dat_i;
        else               tail_d = in_dat_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = in_dat_i;
        end else begin
          head_d = tail_q;
          tail_d = in_dat_i;
        end
      end
      default: ;
    endcase
  end

  // Entry and occupancy registers; reset empties and zeroes both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fft_output_framer.sv
// Frames bit-reversed FFT samples into 2^point-sample frames, tagging the last one; optional scaling via FFT_OUT_SCALE_EN.
// Latency: 1 cycle from fifo pop to output valid (registered head of a 2-entry skid buffer).
// Backpressure: out_ready low stalls the output with stable data; pop stops once the skid buffer is full.
module fft_output_framer
  import fft_output_framer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PT_W-1:0]     point,
  input  logic [2*DATA_W-1:0] data_out,
  input  logic                empty,
  output logic                pop,
  output fft_data_bus_t       out,
  output logic                out_last,
  input  logic                out_ready,
  output logic [FCNT_W-1:0]   frame_cnt,
  output logic                busy
);

  fft_cont_to_comp_t  ctl;
  frame_state_e       state_q, state_d;
  logic [PT_W-1:0]    frame_pt_q, frame_pt_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [FCNT_W-1:0]  frame_cnt_q;
  logic [PT_W-1:0]    pt_use;
  logic               is_last;
  logic               buf_rdy, buf_vld;
  logic [2*DATA_W:0]  buf_in, buf_dat;
  logic [DATA_W-1:0]  sc_r, sc_i;

  assign ctl.point = point;

  // The first sample of a frame uses the live point; later samples use the latched one.
  assign pt_use  = (state_q == ST_IDLE) ? ctl.point : frame_pt_q;
  assign is_last = (sample_cnt_q == last_index(pt_use));
  assign pop     = !rst && !empty && buf_rdy;

`ifdef FFT_OUT_SCALE_EN
  // Arithmetic shift floors negative values, i.e. rounds toward minus infinity.
  assign sc_r = $signed(data_out[2*DATA_W-1:DATA_W]) >>> pt_use;
  assign sc_i = $signed(data_out[DATA_W-1:0]) >>> pt_use;
`else
  assign sc_r = data_out[2*DATA_W-1:DATA_W];
  assign sc_i = data_out[DATA_W-1:0];
`endif

  assign buf_in = {sc_r, sc_i, is_last};

  fft_skid_buf #(.W(2*DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (pop),
    .in_dat_i  (buf_in),
    .in_rdy_o  (buf_rdy),
    .out_vld_o (buf_vld),
    .out_dat_o (buf_dat),
    .out_rdy_i (out_ready)
  );

  assign out.valid  = buf_vld;
  assign out.data_r = buf_dat[2*DATA_W:DATA_W+1];
  assign out.data_i = buf_dat[DATA_W:1];
  assign out_last   = buf_vld && buf_dat[0];
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q == ST_STREAM) || buf_vld;

  // Frame FSM: opens a frame on its first pop, closes it on the pop of the last sample.
  always_comb begin
    state_d      = state_q;
    frame_pt_d   = frame_pt_q;
    sample_cnt_d = sample_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          frame_pt_d = ctl.point;
          if (is_last) begin
            sample_cnt_d = '0;
          end else begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            state_d      = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (pop) begin
          if (is_last) begin
            sample_cnt_d = '0;
            state_d      = ST_IDLE;
          end else begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, latched frame size and sample counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_pt_q   <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_pt_q   <= frame_pt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Completed-frame counter advances when the last word is accepted downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (buf_vld && out_ready && buf_dat[0]) begin
      frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fft_output_framer.sv
// Self-checking bench for fft_output_framer: table of framing scenarios plus directed corner sequences.
// Latency: checks 1-cycle pop-to-output and stall stability against a queue-based reference model.
// Backpressure: exercises always-ready, 1-on/2-off and random out_ready patterns.
`timescale 1ns/1ps
module tb_fft_output_framer;
  import fft_output_framer_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    point = 4'd0;
  logic [63:0]   data_out = 64'h0;
  logic          empty = 1'b1;
  logic          pop;
  fft_data_bus_t out;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic [15:0]   frame_cnt;
  logic          busy;

  always #5 clk = ~clk;

  fft_output_framer dut (
    .clk       (clk),
    .rst       (rst),
    .point     (point),
    .data_out  (data_out),
    .empty     (empty),
    .pop       (pop),
    .out       (out),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  typedef struct {
    int pt;
    int nwords;
    int dmode;
    int rmode;
    int exp_frames;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] src_q[$];
  logic [64:0] exp_q[$];
  int          m_idx, m_pt, m_occ, m_frames, n_out, cyc, rmode;
  logic        chk_rst;
  logic        held_vld;
  logic [64:0] held;
  logic [64:0] first_out;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Floor division by 2^pt when scaling is built in; identity otherwise.
  function automatic logic [31:0] scale(input logic [31:0] v, input int pt);
`ifdef FFT_OUT_SCALE_EN
    real q;
    q = $floor(real'($signed(v)) / (2.0 ** pt));
    return 32'($rtoi(q));
`else
    if (pt < 0) return 32'h0;
    return v;
`endif
  endfunction

  task automatic drive_src();
    empty    = (src_q.size() == 0);
    data_out = empty ? 64'h0 : src_q[0];
  endtask

  task automatic cycle();
    logic did_pop, xfer;
    logic [64:0] cur, e;
    int lastidx;
    did_pop = 1'b0;
    xfer    = 1'b0;
    @(negedge clk);
    cur = {out.data_r, out.data_i, out_last};
    if (rst) begin
      if (chk_rst) begin
        chk("rst_valid", out.valid, 0);
        chk("rst_data_last", cur, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pop", pop, 0);
      end
      held_vld = 1'b0;
    end else begin
      chk("busy", busy, (m_idx != 0) || (m_occ != 0));
      chk("frame_cnt", frame_cnt, 16'(m_frames));
      chk("valid", out.valid, m_occ != 0);
      if (held_vld && out.valid) chk("stall_hold", cur, held);
      did_pop = pop;
      xfer    = out.valid && out_ready;
      chk("pop_when_full", did_pop && (m_occ == 2) && !xfer, 0);
      chk("pop_when_empty", pop && empty, 0);
      if (xfer) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_output: got %0h expected no word (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", cur, e);
          if (e[0]) m_frames++;
        end
        if (n_out == 0) first_out = cur;
        n_out++;
      end
      held_vld = out.valid && !out_ready;
      held     = cur;
      if (did_pop) begin
        if (m_idx == 0) m_pt = int'(point);
        lastidx = (1 << m_pt) - 1;
        e = {scale(data_out[63:32], m_pt), scale(data_out[31:0], m_pt), (m_idx == lastidx)};
        exp_q.push_back(e);
        m_idx = (m_idx == lastidx) ? 0 : m_idx + 1;
      end
      m_occ = m_occ + int'(did_pop) - int'(xfer);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (did_pop) void'(src_q.pop_front());
    drive_src();
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    chk_rst = 1'b0;
    cycle();
    chk_rst = 1'b1;
    cycle();
    chk_rst = 1'b0;
    rst = 1'b0;
    m_idx = 0; m_pt = 0; m_occ = 0; m_frames = 0; n_out = 0;
    held_vld = 1'b0;
    exp_q.delete();
  endtask

  task automatic load(input int n, input int dmode);
    for (int i = 0; i < n; i++) begin
      if (dmode == 0) src_q.push_back(64'(i + 1));
      else            src_q.push_back({$urandom(), $urandom()});
    end
    drive_src();
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (n_out < n && k < budget) begin
      cycle();
      k++;
    end
    chk("out_count", n_out, n);
    cycle();
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{pt: 4, nwords: 64, dmode: 0, rmode: 0, exp_frames: 4};
    tbl[1] = '{pt: 3, nwords: 24, dmode: 1, rmode: 1, exp_frames: 3};
    tbl[2] = '{pt: 0, nwords: 3,  dmode: 0, rmode: 0, exp_frames: 3};
    tbl[3] = '{pt: 2, nwords: 40, dmode: 1, rmode: 2, exp_frames: 10};
    tbl[4] = '{pt: 5, nwords: 64, dmode: 1, rmode: 2, exp_frames: 2};
    tbl[5] = '{pt: 1, nwords: 7,  dmode: 1, rmode: 1, exp_frames: 3};
    cyc = 0; rmode = 0; chk_rst = 1'b0; held_vld = 1'b0; first_out = '0;
    m_idx = 0; m_pt = 0; m_occ = 0; m_frames = 0; n_out = 0;

    for (int t = 0; t < 6; t++) begin
      src_q.delete();
      do_reset();
      point = 4'(tbl[t].pt);
      rmode = tbl[t].rmode;
      out_ready = (rmode != 1);
      load(tbl[t].nwords, tbl[t].dmode);
      run_until(tbl[t].nwords, 2000);
      chk("table_frames", frame_cnt, 16'(tbl[t].exp_frames));
    end

    // Frame size change in the middle of a frame only affects the next frame.
    begin
      int k;
      src_q.delete();
      do_reset();
      point = 4'd4; rmode = 0; out_ready = 1'b1;
      load(20, 0);
      k = 0;
      while (m_idx < 5 && k < 200) begin cycle(); k++; end
      point = 4'd2;
      run_until(20, 500);
      chk("pt_change_frames", frame_cnt, 16'd2);
    end

    // Reset pulse partway through a 16-point frame, then a full fresh frame.
    begin
      int k;
      src_q.delete();
      do_reset();
      point = 4'd4; rmode = 0; out_ready = 1'b1;
      load(30, 1);
      k = 0;
      while (n_out < 7 && k < 200) begin cycle(); k++; end
      do_reset();
      src_q.delete();
      load(16, 0);
      run_until(16, 500);
      chk("post_rst_frames", frame_cnt, 16'd1);
    end

    // Scaling of a negative real / positive imaginary sample at point=4.
    begin
      src_q.delete();
      do_reset();
      point = 4'd4; rmode = 0; out_ready = 1'b1;
      src_q.push_back({32'hFFFF_FFDF, 32'd160});
      load(15, 0);
      run_until(16, 500);
`ifdef FFT_OUT_SCALE_EN
      chk("scale_first", first_out, {32'hFFFF_FFFD, 32'd10, 1'b0});
`else
      chk("scale_first", first_out, {32'hFFFF_FFDF, 32'd160, 1'b0});
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_output_framer.md
FFT_OUTPUT_FRAMER -- requirements
Module: fft_output_framer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: point  in  4  log2 FFT size (from FFT_CONT_TO_COMP.point).
REQ-004 SHALL have ports: data_out  in  64  bitrev_fifo head word {data_r[31:0], data_i[31:0]}, first-word-fall-through.
REQ-005 SHALL have ports: empty  in  1  bitrev_fifo empty flag.
REQ-006 SHALL have ports: pop  out  1  bitrev_fifo pop strobe.
REQ-007 SHALL have ports: out  out  65  FFT_DATA_BUS (valid + data) to consumer.
REQ-008 SHALL have ports: out_last  out  1  marks final sample of a frame.
REQ-009 SHALL have ports: out_ready  in  1  consumer accept.
REQ-010 SHALL have ports: frame_cnt  out  16  completed frames, wraps 0xFFFF->0.
REQ-011 SHALL have ports: busy  out  1  high while a frame is partially emitted.

Function
REQ-012 SHALL treat data_out as valid whenever empty=0; pop=1 consumes it that cycle.
REQ-013 SHALL assert pop only when empty=0 and the internal 2-entry skid buffer has space, including space freed by out.valid&&out_ready that same cycle.
REQ-014 SHALL deliver a popped word on out at the earliest one cycle after pop (registered output, latency 1).
REQ-015 SHALL hold out.data and out_last stable while out.valid=1 and out_ready=0.
REQ-016 SHALL transfer a word only on out.valid&&out_ready; no word dropped or duplicated.
REQ-017 SHALL latch point into frame_pt on the pop of a frame's first sample; point changes mid-frame are ignored until the next frame.
REQ-018 SHALL count samples 0..2^frame_pt-1 with a 16-bit counter; frame_pt=0 gives 1-sample frames.
REQ-019 SHALL set out_last on the word with sample index 2^frame_pt-1 and then wrap the counter to 0.
REQ-020 SHALL increment frame_cnt on the cycle the out_last word transfers.
REQ-021 SHALL use states IDLE (count=0, no frame open) and STREAM (frame open): IDLE->STREAM on first pop; STREAM->IDLE on pop of last sample; busy=1 in STREAM or while buffer non-empty.
REQ-022 SHALL, on simultaneous pop and output transfer with buffer full, keep occupancy unchanged and ordering FIFO.

Reset
REQ-023 SHALL on rst=1 clear out.valid, out.data, out_last, pop, frame_cnt, busy, sample counter, frame_pt and buffer to 0 and enter IDLE.
REQ-024 SHALL on rst mid-frame discard buffered words; the next popped word starts a new frame.

Configuration
REQ-025 SHALL with FFT_OUT_SCALE_EN defined arithmetic-right-shift data_r and data_i (signed 32-bit) by frame_pt before buffering, rounding toward minus infinity.
REQ-026 SHALL without FFT_OUT_SCALE_EN pass data bit-exact, with no shifter logic.

Structure
REQ-027 SHALL take FFT_DATA_BUS, FFT_CONT_TO_COMP and constants DATA_W=32, PT_W=4, FCNT_W=16 from the shared FFT package.
REQ-028 SHALL implement the 2-entry buffer as sub-module fft_skid_buf, parameterised on payload width (65: data + last).

Verification
REQ-029 SHALL cover: point=4, 64 words 1..64 in fifo, out_ready=1 -> 64 outputs in order, out_last on 16,32,48,64, frame_cnt=4.
REQ-030 SHALL cover: out_ready toggling 1 cycle on / 2 off, point=3 -> no loss or duplication, data stable while stalled, pop never while buffer full.
REQ-031 SHALL cover: point changed 4->2 after sample 5 of a frame -> out_last still on sample 16, next frame 4 samples long.
REQ-032 SHALL cover: rst pulsed after sample 7 of a 16-point frame -> outputs clear next cycle; following 16 words form a full frame with out_last on the 16th.
REQ-033 SHALL cover: FFT_OUT_SCALE_EN, point=4, input data_r=-33, data_i=160 -> out data_r=-3, data_i=10; without macro -> -33, 160.
REQ-034 SHALL cover: point=0, 3 words -> every word has out_last=1, frame_cnt=3.
